// File: rtl/conv_relu_pool_stream_pkg.sv
// Shared state encoding, dimension helpers and saturating arithmetic for the
// streaming convolution layer engine.
package conv_layer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_BIAS = 3'd1,
    LOAD_KRNL = 3'd2,
    LOAD_IMG  = 3'd3,
    CONV      = 3'd4,
    EMIT      = 3'd5,
    FINISH    = 3'd6
  } state_e;

  function automatic int conv_dim(input int in_dim, input int ksize);
    return in_dim - ksize + 1;
  endfunction

  function automatic int out_dim(input int in_dim, input int ksize, input int pool_en);
    return (pool_en != 0) ? conv_dim(in_dim, ksize) / 2 : conv_dim(in_dim, ksize);
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] value, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    else if (value < lo) return lo;
    else return value;
  endfunction

  function automatic logic signed [63:0] relu(input logic signed [63:0] value);
    return (value < 64'sd0) ? 64'sd0 : value;
  endfunction

endpackage

// File: rtl/conv_relu_pool_stream_if.sv
// Control plus input/output ready-valid streams of one convolution layer;
// the layer is the slave, the feeding/draining logic is the master.
interface conv_relu_pool_stream_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 12
);
  logic              start;
  logic              busy;
  logic              done;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [OUT_W-1:0]  out_data;

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output busy, done, in_ready, out_valid, out_data, out_last
  );

  modport master (
    output start, in_valid, in_data, out_ready,
    input  busy, done, in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv_relu_pool_stream_mac.sv
// Registered signed multiply-accumulate: the first term of a window adds onto
// the bias instead of the running sum; every step saturates to ACC_W bits.
module conv_mac_sat
  import conv_layer_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int W_W   = 4,
  parameter int ACC_W = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_en,
  input  logic                    i_first,
  input  logic signed [IN_W-1:0]  i_pix,
  input  logic signed [W_W-1:0]   i_wgt,
  input  logic signed [W_W-1:0]   i_bias,
  output logic signed [ACC_W-1:0] o_acc
);
  logic signed [IN_W+W_W-1:0] w_prod;
  logic signed [63:0]         w_sum;
  logic signed [ACC_W-1:0]    w_sat;
  logic signed [ACC_W-1:0]    r_acc;

  assign w_prod = (IN_W+W_W)'(i_pix) * (IN_W+W_W)'(i_wgt);
  assign w_sum  = (i_first ? 64'(i_bias) : 64'(r_acc)) + 64'(w_prod);
  assign w_sat  = ACC_W'(saturate(w_sum, ACC_W));

  // Accumulator register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_sat;
    end
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/conv_relu_pool_stream.sv
// Streaming convolution layer: loads bias, kernel and image over one input stream,
// then computes conv + bias + ReLU (+ optional 2x2 max pool) at one MAC per cycle.
module conv_relu_pool_stream
  import conv_layer_pkg::*;
#(
  parameter int IN_DIM  = 13,
  parameter int IN_CH   = 32,
  parameter int OUT_CH  = 64,
  parameter int KSIZE   = 3,
  parameter int IN_W    = 8,
  parameter int W_W     = 4,
  parameter int ACC_W   = 20,
  parameter int OUT_W   = 12,
  parameter int POOL_EN = 1
) (
  input logic clock,
  input logic reset,
  conv_relu_pool_stream_if.slave s
);
  localparam int ODIM   = out_dim(IN_DIM, KSIZE, POOL_EN);
  localparam int PS     = (POOL_EN != 0) ? 2 : 1;
  localparam int N_WIN  = (POOL_EN != 0) ? 4 : 1;
  localparam int N_BIAS = OUT_CH;
  localparam int N_KRNL = KSIZE * KSIZE * IN_CH * OUT_CH;
  localparam int N_IMG  = IN_DIM * IN_DIM * IN_CH;
  localparam int BA_W   = (N_BIAS > 1) ? $clog2(N_BIAS) : 1;
  localparam int KA_W   = (N_KRNL > 1) ? $clog2(N_KRNL) : 1;
  localparam int IA_W   = (N_IMG > 1) ? $clog2(N_IMG) : 1;

  logic [2:0]              r_state;
  logic                    r_in_ready, r_out_valid, r_out_last, r_busy, r_done, r_fin;
  logic signed [OUT_W-1:0] r_out_data, r_max;
  logic [31:0]             r_ld_cnt, r_oy, r_ox, r_oc, r_ky, r_kx, r_ic;
  logic [1:0]              r_win;
  logic signed [W_W-1:0]   r_bias [N_BIAS];
  logic signed [W_W-1:0]   r_krnl [N_KRNL];
  logic signed [IN_W-1:0]  r_img  [N_IMG];

  logic                    w_take, w_mac_en, w_mac_first, w_win_end, w_is_last;
  logic [31:0]             w_row, w_col;
  logic [IA_W-1:0]         w_pix_addr;
  logic [KA_W-1:0]         w_krn_addr;
  logic signed [ACC_W-1:0] w_acc;
  logic signed [OUT_W-1:0] w_res, w_max;

  assign w_take      = s.in_valid && r_in_ready;
  assign w_mac_en    = (r_state == CONV) && !r_fin;
  assign w_mac_first = (r_ky == 32'd0) && (r_kx == 32'd0) && (r_ic == 32'd0);
  assign w_win_end   = (r_ky == 32'(KSIZE-1)) && (r_kx == 32'(KSIZE-1)) && (r_ic == 32'(IN_CH-1));
  assign w_is_last   = (r_oy == 32'(ODIM-1)) && (r_ox == 32'(ODIM-1)) && (r_oc == 32'(OUT_CH-1));

  // r_win[1]/r_win[0] select the row/column of the 2x2 pool sub-window.
  assign w_row      = r_oy * 32'(PS) + 32'(r_win[1]) + r_ky;
  assign w_col      = r_ox * 32'(PS) + 32'(r_win[0]) + r_kx;
  assign w_pix_addr = IA_W'((w_row * 32'(IN_DIM) + w_col) * 32'(IN_CH) + r_ic);
  assign w_krn_addr = KA_W'(((r_kx * 32'(KSIZE) + r_ky) * 32'(IN_CH) + r_ic) * 32'(OUT_CH) + r_oc);

  // Running max starts at 0 per output, which is exact because w_res is post-ReLU.
  assign w_res = OUT_W'(saturate(relu(64'(w_acc)), OUT_W));
  assign w_max = (w_res > r_max) ? w_res : r_max;

  conv_mac_sat #(.IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W)) u_mac (
    .clock   (clock),
    .reset   (reset),
    .i_en    (w_mac_en),
    .i_first (w_mac_first),
    .i_pix   (r_img[w_pix_addr]),
    .i_wgt   (r_krnl[w_krn_addr]),
    .i_bias  (r_bias[r_oc[BA_W-1:0]]),
    .o_acc   (w_acc)
  );

  // Buffer writes, addressed by the load counter of the active phase.
  always_ff @(posedge clock) begin
    if (w_take) begin
      case (r_state)
        LOAD_BIAS: r_bias[r_ld_cnt[BA_W-1:0]] <= s.in_data[W_W-1:0];
        LOAD_KRNL: r_krnl[r_ld_cnt[KA_W-1:0]] <= s.in_data[W_W-1:0];
        LOAD_IMG:  r_img[r_ld_cnt[IA_W-1:0]]  <= s.in_data[IN_W-1:0];
        default: ;
      endcase
    end
  end

  // Control FSM, load/compute/output counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fin       <= 1'b0;
      r_max       <= '0;
      r_win       <= 2'd0;
      r_ld_cnt    <= 32'd0;
      r_oy        <= 32'd0;
      r_ox        <= 32'd0;
      r_oc        <= 32'd0;
      r_ky        <= 32'd0;
      r_kx        <= 32'd0;
      r_ic        <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (s.start) begin
            r_state    <= LOAD_BIAS;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
            r_ld_cnt   <= 32'd0;
            r_oy       <= 32'd0;
            r_ox       <= 32'd0;
            r_oc       <= 32'd0;
            r_ky       <= 32'd0;
            r_kx       <= 32'd0;
            r_ic       <= 32'd0;
            r_win      <= 2'd0;
            r_fin      <= 1'b0;
            r_max      <= '0;
          end
        end
        LOAD_BIAS: begin
          if (w_take) begin
            if (r_ld_cnt == 32'(N_BIAS-1)) begin
              r_ld_cnt <= 32'd0;
              r_state  <= LOAD_KRNL;
            end else begin
              r_ld_cnt <= r_ld_cnt + 32'd1;
            end
          end
        end
        LOAD_KRNL: begin
          if (w_take) begin
            if (r_ld_cnt == 32'(N_KRNL-1)) begin
              r_ld_cnt <= 32'd0;
              r_state  <= LOAD_IMG;
            end else begin
              r_ld_cnt <= r_ld_cnt + 32'd1;
            end
          end
        end
        LOAD_IMG: begin
          if (w_take) begin
            if (r_ld_cnt == 32'(N_IMG-1)) begin
              r_ld_cnt   <= 32'd0;
              r_in_ready <= 1'b0;
              r_state    <= CONV;
            end else begin
              r_ld_cnt <= r_ld_cnt + 32'd1;
            end
          end
        end
        CONV: begin
          if (!r_fin) begin
            if (w_win_end) begin
              r_fin <= 1'b1;
              r_ky  <= 32'd0;
              r_kx  <= 32'd0;
              r_ic  <= 32'd0;
            end else if (r_ic == 32'(IN_CH-1)) begin
              r_ic <= 32'd0;
              if (r_kx == 32'(KSIZE-1)) begin
                r_kx <= 32'd0;
                r_ky <= r_ky + 32'd1;
              end else begin
                r_kx <= r_kx + 32'd1;
              end
            end else begin
              r_ic <= r_ic + 32'd1;
            end
          end else begin
            r_fin <= 1'b0;
            if (r_win != 2'(N_WIN-1)) begin
              r_win <= r_win + 2'd1;
              r_max <= w_max;
            end else begin
              r_win       <= 2'd0;
              r_max       <= '0;
              r_out_data  <= w_max;
              r_out_valid <= 1'b1;
              r_out_last  <= w_is_last;
              r_state     <= EMIT;
            end
          end
        end
        EMIT: begin
          if (s.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_out_last) begin
              r_state <= FINISH;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= CONV;
              if (r_oc == 32'(OUT_CH-1)) begin
                r_oc <= 32'd0;
                if (r_ox == 32'(ODIM-1)) begin
                  r_ox <= 32'd0;
                  r_oy <= r_oy + 32'd1;
                end else begin
                  r_ox <= r_ox + 32'd1;
                end
              end else begin
                r_oc <= r_oc + 32'd1;
              end
            end
          end
        end
        FINISH:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s.in_ready  = r_in_ready;
  assign s.out_valid = r_out_valid;
  assign s.out_data  = r_out_data;
  assign s.out_last  = r_out_last;
  assign s.busy      = r_busy;
  assign s.done      = r_done;
endmodule
